// File: rtl/gpr_wb_queue.sv
// Writeback queue in front of the GPR write port: buffers MEM/WB writes, issues one per cycle,
// and forwards every write the register file's registered read port cannot yet show.
module gpr_wb_queue #(
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wb_valid,
   output logic          wb_ready,
   input  logic [4:0]    wb_rd,
   input  logic [31:0]   wb_data,
   input  logic          gpr_busy,
   output logic          gpr_we,
   output logic [4:0]    gpr_rd,
   output logic [31:0]   gpr_wdata,
   input  logic [4:0]    rs_addr,
   input  logic [4:0]    rt_addr,
   output logic          rs_hit,
   output logic [31:0]   rs_fwd,
   output logic          rt_hit,
   output logic [31:0]   rt_fwd,
   output logic [AW:0]   count
);

   logic [4:0]    q_rd   [DEPTH];
   logic [31:0]   q_data [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic          ret_v;
   logic [4:0]    ret_rd;
   logic [31:0]   ret_data;
   logic          push;
   logic          pop;

   // Ready depends only on occupancy, so gpr_busy never reaches wb_ready combinationally.
   assign wb_ready = (count != (AW+1)'(DEPTH));
   assign push     = wb_valid & wb_ready & (wb_rd != 5'd0);
   assign pop      = (count != '0) & ~gpr_busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         gpr_we    <= 1'b0;
         gpr_rd    <= '0;
         gpr_wdata <= '0;
         ret_v     <= 1'b0;
         ret_rd    <= '0;
         ret_data  <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pop) begin
            gpr_we    <= 1'b1;
            gpr_rd    <= q_rd[head];
            gpr_wdata <= q_data[head];
         end else begin
            gpr_we    <= 1'b0;
         end
         ret_v    <= gpr_we;
         ret_rd   <= gpr_rd;
         ret_data <= gpr_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[tail]   <= wb_rd;
         q_data[tail] <= wb_data;
      end
   end

   // Oldest source first so that each younger match overrides; result is {hit, data}.
   function automatic logic [32:0] lookup(input logic [4:0] addr);
      logic [32:0]   res;
      logic [AW-1:0] idx;
      res = '0;
      if (ret_v && (ret_rd == addr)) res = {1'b1, ret_data};
      if (gpr_we && (gpr_rd == addr)) res = {1'b1, gpr_wdata};
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + AW'(i);
         if (((AW+1)'(i) < count) && (q_rd[idx] == addr)) res = {1'b1, q_data[idx]};
      end
      if (addr == 5'd0) res = '0;
      return res;
   endfunction

   always_comb begin
      {rs_hit, rs_fwd} = lookup(rs_addr);
      {rt_hit, rt_fwd} = lookup(rt_addr);
   end

endmodule
